nasti_buf: RTL
==============

# nasti_buf

Parametrised five-channel NASTI buffer. It sits between a NASTI master port and a slave port and inserts an independent FIFO of configurable depth on each of AW, W, B, AR and R, or a zero-latency bypass on any channel. It breaks timing paths, absorbs burst backpressure and reports when the whole slice is drained. It supersedes hand-instantiated per-channel register slices in crossbars and bridges.

## Interface
Parameters:
- ID_WIDTH, 1, ID field width on AW/B/AR/R
- ADDR_WIDTH, 8, address width on AW/AR
- DATA_WIDTH, 8, data width on W/R; multiple of 8
- USER_WIDTH, 1, user field width on all channels
- AW_DEPTH, 2, AW FIFO depth; 0 = bypass, else power of two ≥1
- W_DEPTH, 2, W FIFO depth; same rule
- B_DEPTH, 2, B FIFO depth; same rule
- AR_DEPTH, 2, AR FIFO depth; same rule
- R_DEPTH, 2, R FIFO depth; same rule

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- s_aw, s_w, s_ar  interface  nasti_aw/nasti_w/nasti_ar  upstream request channels (buffer is receiver)
- s_b, s_r  interface  nasti_b/nasti_r  upstream response channels (buffer is sender)
- m_aw, m_w, m_ar  interface  same types  downstream request channels (buffer is sender)
- m_b, m_r  interface  same types  downstream response channels (buffer is receiver)
- idle  output  1  high when every non-bypass FIFO is empty

## Operation
- Each channel is one instance of a generic FIFO. The payload is the concatenation of every non-handshake field of that channel:
  - AW/AR: id, addr, len, size, burst, cache, prot, qos, region, user
  - W: data, strb, last, user
  - B: id, resp, user
  - R: id, data, resp, last, user
- Payload width = sum of field widths, derived from parameters. Fields pass through unmodified and in order.
- Depth 0 (bypass): valid, payload and ready are wired straight through. No state, no reset effect. The channel is excluded from idle.
- Depth N ≥1: circular buffer of N entries.
  - Read and write pointers are log2(N) bits (1 bit minimum) and wrap modulo N.
  - Occupancy counter is log2(N)+1 bits, range 0..N.
- Push when in.valid && in.ready. Pop when out.valid && out.ready.
  - count' = count + push − pop.
  - Simultaneous push and pop keeps count unchanged and advances both pointers.
- in.ready = !rst && (count != N). This is a registered-state function only, with no combinational path from out.ready. When full, a same-cycle pop does not raise in.ready.
- out.valid = (count != 0). out payload = mem[rd_ptr], first-word-fall-through from storage, no combinational path from in.valid.
- A transfer with valid held but ready low is not a push or pop. Upstream must hold payload stable (NASTI rule); the FIFO does not check this.
- Channels are fully independent. No cross-channel ordering, reordering or ID interpretation.
- idle = AND over non-bypass channels of (count == 0). Constant 1 if all channels are bypass.

## Timing
- Reset (rst sampled high): all counts and pointers cleared. Entries are flushed without being delivered. out.valid = 0 and in.ready = 0 while rst is high; idle = 1 from the first cycle after rst is sampled.
- First cycle after rst deasserts: in.ready = 1, out.valid = 0.
- Reset mid-burst: in-flight entries are discarded. The bench treats this as a bus-wide reset, and both sides reset together.
- Latency, depth ≥1: a beat pushed in cycle t appears on out.valid in cycle t+1 (one cycle, empty FIFO). With depth-1 occupancy ahead of it, it appears after those beats drain.
- Throughput:
  - Depth ≥2: one beat per cycle sustained when downstream is always ready.
  - Depth 1: one beat per two cycles, by construction, because in.ready does not look ahead.
- Full: with count = N, in.ready = 0 until the cycle after a pop.
- Empty: with count = 0, out.valid = 0 and the out payload is don't-care.
- Bypass: zero cycles, purely combinational.

## Test plan
- Reset and idle: hold rst 3 cycles with s_aw.valid = 1 → s_aw.ready = 0, m_aw.valid = 0, idle = 1. After release, s_aw.ready = 1 on the first cycle.
- Single beat, AW_DEPTH=2: push AW id=1 addr=0x40 len=3 in cycle 5 → m_aw.valid = 1 with identical fields in cycle 6. idle = 0 in cycle 6 and returns to 1 after the pop.
- Full/backpressure, W_DEPTH=4: m_w.ready = 0, push 6 beats data 0x01..0x06 → 4 accepted, s_w.ready = 0 after the 4th. Release m_w.ready → data 0x01..0x06 out in order; 0x06 carries last = 1.
- Sustained throughput plus wrap, R_DEPTH=2: 16 back-to-back R beats with both sides always ready → 16 beats in 17 cycles, pointers wrap 8 times, no loss or duplication.
- Depth 1 and bypass: B_DEPTH=1 with 4 beats, downstream ready → 4 beats in 8 cycles. AR_DEPTH=0 → m_ar mirrors s_ar in the same cycle, s_ar.ready = m_ar.ready combinationally.
- Reset mid-operation: R FIFO holding 2 beats, assert rst for 1 cycle → next cycle s_r.valid = 0 and idle = 1. The held beats are never delivered.

Source files
------------

// File: rtl/nasti_buf_if.sv
// NASTI channel interfaces. "master" is the NASTI master side of each channel,
// "slave" the NASTI slave side, so request channels flow master->slave and B/R flow back.

interface nasti_aw #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;

    modport master (output valid, id, addr, len, size, burst, cache, prot, qos, region, user,
                    input ready);
    modport slave  (input valid, id, addr, len, size, burst, cache, prot, qos, region, user,
                    output ready);
endinterface

interface nasti_ar #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;

    modport master (output valid, id, addr, len, size, burst, cache, prot, qos, region, user,
                    input ready);
    modport slave  (input valid, id, addr, len, size, burst, cache, prot, qos, region, user,
                    output ready);
endinterface

interface nasti_w #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    last;
    logic [USER_WIDTH-1:0]   user;

    modport master (output valid, data, strb, last, user, input ready);
    modport slave  (input valid, data, strb, last, user, output ready);
endinterface

interface nasti_b #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;

    modport master (input valid, id, resp, user, output ready);
    modport slave  (output valid, id, resp, user, input ready);
endinterface

interface nasti_r #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [USER_WIDTH-1:0] user;

    modport master (input valid, id, data, resp, last, user, output ready);
    modport slave  (output valid, id, data, resp, last, user, input ready);
endinterface

// File: rtl/nasti_buf.sv
// Five-channel NASTI buffer: one FIFO (or combinational bypass when depth is 0) per channel,
// with idle flagging that every buffering FIFO is empty.

module nasti_buf #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned AW_DEPTH   = 2,
    parameter int unsigned W_DEPTH    = 2,
    parameter int unsigned B_DEPTH    = 2,
    parameter int unsigned AR_DEPTH   = 2,
    parameter int unsigned R_DEPTH    = 2
) (
    input  logic      clk,
    input  logic      rst,
    nasti_aw.slave    s_aw,
    nasti_w.slave     s_w,
    nasti_b.slave     s_b,
    nasti_ar.slave    s_ar,
    nasti_r.slave     s_r,
    nasti_aw.master   m_aw,
    nasti_w.master    m_w,
    nasti_b.master    m_b,
    nasti_ar.master   m_ar,
    nasti_r.master    m_r,
    output logic      idle
);

    localparam int unsigned AxW = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 4 + 3 + 4 + 4 + USER_WIDTH;
    localparam int unsigned WW  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;
    localparam int unsigned BW  = ID_WIDTH + 2 + USER_WIDTH;
    localparam int unsigned RW  = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

    // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R
    function automatic int unsigned ch_depth(int unsigned c);
        case (c)
            0:       return AW_DEPTH;
            1:       return W_DEPTH;
            2:       return B_DEPTH;
            3:       return AR_DEPTH;
            default: return R_DEPTH;
        endcase
    endfunction

    function automatic int unsigned ch_width(int unsigned c);
        case (c)
            0, 3:    return AxW;
            1:       return WW;
            2:       return BW;
            default: return RW;
        endcase
    endfunction

    logic [4:0] in_valid, in_ready, out_valid, out_ready, ch_empty;

    for (genvar c = 0; c < 5; c++) begin : g_ch
        localparam int unsigned D  = ch_depth(c);
        localparam int unsigned PW = ch_width(c);

        logic [PW-1:0] in_d, out_d;

        // Request channels enter from s_*, response channels enter from m_*
        if (c == 0) begin : g_aw
            assign in_valid[c] = s_aw.valid;
            assign s_aw.ready  = in_ready[c];
            assign in_d = {s_aw.id, s_aw.addr, s_aw.len, s_aw.size, s_aw.burst, s_aw.cache,
                           s_aw.prot, s_aw.qos, s_aw.region, s_aw.user};
            assign m_aw.valid  = out_valid[c];
            assign out_ready[c] = m_aw.ready;
            assign {m_aw.id, m_aw.addr, m_aw.len, m_aw.size, m_aw.burst, m_aw.cache,
                    m_aw.prot, m_aw.qos, m_aw.region, m_aw.user} = out_d;
        end else if (c == 1) begin : g_w
            assign in_valid[c] = s_w.valid;
            assign s_w.ready   = in_ready[c];
            assign in_d = {s_w.data, s_w.strb, s_w.last, s_w.user};
            assign m_w.valid   = out_valid[c];
            assign out_ready[c] = m_w.ready;
            assign {m_w.data, m_w.strb, m_w.last, m_w.user} = out_d;
        end else if (c == 2) begin : g_b
            assign in_valid[c] = m_b.valid;
            assign m_b.ready   = in_ready[c];
            assign in_d = {m_b.id, m_b.resp, m_b.user};
            assign s_b.valid   = out_valid[c];
            assign out_ready[c] = s_b.ready;
            assign {s_b.id, s_b.resp, s_b.user} = out_d;
        end else if (c == 3) begin : g_ar
            assign in_valid[c] = s_ar.valid;
            assign s_ar.ready  = in_ready[c];
            assign in_d = {s_ar.id, s_ar.addr, s_ar.len, s_ar.size, s_ar.burst, s_ar.cache,
                           s_ar.prot, s_ar.qos, s_ar.region, s_ar.user};
            assign m_ar.valid  = out_valid[c];
            assign out_ready[c] = m_ar.ready;
            assign {m_ar.id, m_ar.addr, m_ar.len, m_ar.size, m_ar.burst, m_ar.cache,
                    m_ar.prot, m_ar.qos, m_ar.region, m_ar.user} = out_d;
        end else begin : g_r
            assign in_valid[c] = m_r.valid;
            assign m_r.ready   = in_ready[c];
            assign in_d = {m_r.id, m_r.data, m_r.resp, m_r.last, m_r.user};
            assign s_r.valid   = out_valid[c];
            assign out_ready[c] = s_r.ready;
            assign {s_r.id, s_r.data, s_r.resp, s_r.last, s_r.user} = out_d;
        end

        if (D == 0) begin : g_bypass
            assign out_valid[c] = in_valid[c];
            assign in_ready[c]  = out_ready[c];
            assign out_d        = in_d;
            assign ch_empty[c]  = 1'b1;
        end else begin : g_fifo
            localparam int unsigned PtrW = (D > 1) ? $clog2(D) : 1;
            localparam int unsigned CntW = $clog2(D) + 1;
            localparam int unsigned MemD = 1 << PtrW;

            logic [PW-1:0]   mem_q [MemD];
            logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
            logic [CntW-1:0] cnt_q, cnt_d;
            logic            push, pop;

            // ready depends only on registered count, never on out_ready
            assign in_ready[c]  = !rst && (cnt_q != CntW'(D));
            assign out_valid[c] = !rst && (cnt_q != '0);
            assign push         = in_valid[c] && in_ready[c];
            assign pop          = out_valid[c] && out_ready[c];
            assign out_d        = mem_q[rd_ptr_q];
            assign ch_empty[c]  = (cnt_q == '0);

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push) begin
                    wr_ptr_d = (wr_ptr_q == PtrW'(D - 1)) ? '0 : wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_d = (rd_ptr_q == PtrW'(D - 1)) ? '0 : rd_ptr_q + PtrW'(1);
                end
                cnt_d = cnt_q + CntW'(push) - CntW'(pop);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_d;
                end
            end
        end
    end

    assign idle = &ch_empty;

endmodule
